conv_chan_sequencer: RTL and testbench
======================================

CONV_CHAN_SEQUENCER -- requirements
Module: conv_chan_sequencer

Interface
REQ-001 SHALL have parameters: OUT_H, default 12, conv output rows; OUT_W, default 11, conv output columns; CHAN, default 10, channel count; DATA_WIDTH, default 24, pixel width; TIMEOUT, default 1023, maximum wait cycles per channel.
REQ-002 SHALL define local P_H = OUT_H/2 and P_W = OUT_W/2, both floor division, and NBEAT = P_H*P_W.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 start  input  1  begins a full CHAN-channel run; sampled only in IDLE.
REQ-006 conv_trigger  output  1  one-cycle start pulse to the conv engine.
REQ-007 conv_chan  output  4  channel select to the conv engine; held stable from trigger until capture.
REQ-008 conv_valid  input  1  one-cycle pulse from the conv engine; conv_buff is complete when it is high.
REQ-009 conv_out_chan  input  4  channel tag returned with conv_valid.
REQ-010 conv_buff  input  signed DATA_WIDTH array [OUT_H][OUT_W]  conv result map.
REQ-011 pool_data  output  signed DATA_WIDTH  pooled pixel.
REQ-012 pool_valid  output  1  pool_data is valid.
REQ-013 pool_ready  input  1  downstream accepts the beat.
REQ-014 pool_chan  output  4  channel of the current beat.
REQ-015 pool_idx  output  8  beat index, row-major r*P_W+c.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse when a run ends.
REQ-018 err  output  1  sticky error flag, cleared by an accepted start.

Function
REQ-019 FSM states SHALL be IDLE, TRIG, WAIT, LOAD, EMIT, DONE.
REQ-020 IDLE: on start=1, SHALL set chan=0, clear err, and go to TRIG; start in any other state SHALL be ignored.
REQ-021 TRIG: SHALL assert conv_trigger for exactly one cycle with conv_chan=chan, clear the wait counter, and go to WAIT.
REQ-022 WAIT: on conv_valid=1, SHALL copy all of conv_buff into an internal map and go to LOAD.
REQ-023 WAIT: if conv_out_chan≠chan when conv_valid=1, SHALL set err and still capture.
REQ-024 WAIT: if conv_valid stays low for TIMEOUT+1 consecutive cycles, SHALL set err and go to DONE, aborting the run.
REQ-025 LOAD: SHALL register beat 0 into pool_data, set pool_idx=0, pool_chan=chan, and pool_valid=1, then go to EMIT.
REQ-026 Beat (r,c) SHALL equal the max of ReLU(m[2r+i][2c+j]) for i,j∈{0,1}, where ReLU(x)=0 for x<0, else x.
REQ-027 Odd trailing row or column (col 10 at defaults) SHALL be discarded.
REQ-028 Beat results SHALL be non-negative and DATA_WIDTH bits, with no truncation.
REQ-029 EMIT: while pool_valid=1 and pool_ready=0, pool_data, pool_idx and pool_chan SHALL hold stable.
REQ-030 EMIT: on handshake with pool_idx<NBEAT-1, SHALL load the next beat on the same edge, keeping pool_valid=1 (one beat per cycle throughput).
REQ-031 EMIT: on handshake of beat NBEAT-1, SHALL drop pool_valid, then go to DONE if chan=CHAN-1, else set chan+1 and go to TRIG.
REQ-032 DONE: SHALL pulse done for one cycle and return to IDLE.
REQ-033 A conv_valid pulse outside WAIT SHALL be ignored and SHALL NOT set err.
REQ-034 Minimum latency per channel, from TRIG to first pool_valid, SHALL be the conv latency plus 2 cycles.

Reset
REQ-035 On rst_n=0, SHALL immediately force IDLE regardless of state.
REQ-036 On rst_n=0, conv_trigger, pool_valid, busy, done and err SHALL be 0.
REQ-037 On rst_n=0, conv_chan, pool_chan, pool_idx and pool_data SHALL be 0.
REQ-038 After reset release, a new start SHALL run normally with no residue from the interrupted run.

Verification
REQ-039 conv_buff m[r][c]=16r+c, pool_ready=1, conv model answers each trigger after 133 cycles -> 300 beats total; beat (0,0)=17; beat (5,4)=185; pool_chan steps 0..9; a single done pulse; err=0.
REQ-040 conv_buff all -5 -> all 30 beats per channel equal 0.
REQ-041 pool_ready toggled randomly -> every beat is held stable until accepted; no beat is dropped or duplicated; pool_idx is contiguous 0..29.
REQ-042 conv model returns conv_out_chan=3 while chan=2 -> err=1; channel 2 still emits 30 beats; run completes.
REQ-043 conv model never answers channel 4 -> err=1 exactly 1024 cycles after WAIT is entered; done pulses; beats observed only for channels 0..3.
REQ-044 rst_n pulled low in EMIT at beat 12 -> all outputs are 0 in the same cycle; a later start runs channels 0..9 cleanly.

Source files
------------

// File: rtl/conv_chan_sequencer.sv
// conv_chan_sequencer: for each of CHAN channels, triggers the conv engine,
// captures its result map, then streams the 2x2 max-pooled ReLU map
// row-major over a valid/ready interface, one beat per cycle.
module conv_chan_sequencer #(
  parameter int OUT_H      = 12,
  parameter int OUT_W      = 11,
  parameter int CHAN       = 10,
  parameter int DATA_WIDTH = 24,
  parameter int TIMEOUT    = 1023
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         conv_trigger,
  output logic [3:0]                   conv_chan,
  input  logic                         conv_valid,
  input  logic [3:0]                   conv_out_chan,
  input  logic signed [DATA_WIDTH-1:0] conv_buff [OUT_H][OUT_W],
  output logic signed [DATA_WIDTH-1:0] pool_data,
  output logic                         pool_valid,
  input  logic                         pool_ready,
  output logic [3:0]                   pool_chan,
  output logic [7:0]                   pool_idx,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int P_H   = OUT_H / 2;
  localparam int P_W   = OUT_W / 2;
  localparam int NBEAT = P_H * P_W;
  localparam int IW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int WW    = $clog2(TIMEOUT + 2);

  localparam logic [WW-1:0] WAIT_MAX  = WW'(TIMEOUT);
  localparam logic [3:0]    LAST_CHAN = 4'(CHAN - 1);
  localparam logic [7:0]    LAST_IDX  = 8'(NBEAT - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT, LOAD, EMIT, DONE} state_t;

  state_t state, state_nx;

  logic [3:0]                   chan;
  logic [WW-1:0]                wait_cnt;
  logic signed [DATA_WIDTH-1:0] map    [OUT_H][OUT_W];
  logic signed [DATA_WIDTH-1:0] pooled [NBEAT];
  logic [IW-1:0]                next_idx;

  logic capture;
  logic last_beat;

  assign capture   = (state == WAIT) && conv_valid;
  assign last_beat = (pool_idx == LAST_IDX);
  assign next_idx  = pool_idx[IW-1:0] + IW'(1);
  assign conv_chan = chan;

  // Pooled value for every beat, built from the captured map; the trailing
  // odd row/column is never referenced.
  for (genvar r = 0; r < P_H; r++) begin : g_row
    for (genvar c = 0; c < P_W; c++) begin : g_col
      logic signed [DATA_WIDTH-1:0] top_max, bot_max, win_max;
      assign top_max = (map[2*r][2*c] > map[2*r][2*c+1]) ? map[2*r][2*c] : map[2*r][2*c+1];
      assign bot_max = (map[2*r+1][2*c] > map[2*r+1][2*c+1]) ? map[2*r+1][2*c] : map[2*r+1][2*c+1];
      assign win_max = (top_max > bot_max) ? top_max : bot_max;
      // ReLU of the window max equals the max of the ReLU'd pixels.
      assign pooled[r*P_W+c] = win_max[DATA_WIDTH-1] ? '0 : win_max;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nx     = state;
    conv_trigger = 1'b0;
    busy         = (state != IDLE);
    done         = 1'b0;
    case (state)
      IDLE: if (start) state_nx = TRIG;
      TRIG: begin
        conv_trigger = 1'b1;
        state_nx     = WAIT;
      end
      WAIT: begin
        if (conv_valid)                state_nx = LOAD;
        else if (wait_cnt == WAIT_MAX) state_nx = DONE;
      end
      LOAD: state_nx = EMIT;
      EMIT: begin
        if (pool_ready && last_beat) state_nx = (chan == LAST_CHAN) ? DONE : TRIG;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Capture of the conv result map.
  // NOTE: the map is pure datapath, overwritten before it is ever read, so it
  // carries no reset; that keeps a large array out of the reset tree.
  always_ff @(posedge clk) begin
    if (capture) map <= conv_buff;
  end

  // Channel, timeout, error and output-beat registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan       <= '0;
      wait_cnt   <= '0;
      err        <= 1'b0;
      pool_data  <= '0;
      pool_valid <= 1'b0;
      pool_chan  <= '0;
      pool_idx   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          chan <= '0;
          err  <= 1'b0;
        end
        TRIG: wait_cnt <= '0;
        WAIT: begin
          if (conv_valid) begin
            if (conv_out_chan != chan) err <= 1'b1;
          end else if (wait_cnt == WAIT_MAX) begin
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        LOAD: begin
          pool_data  <= pooled[0];
          pool_idx   <= '0;
          pool_chan  <= chan;
          pool_valid <= 1'b1;
        end
        EMIT: if (pool_ready) begin
          if (last_beat) begin
            pool_valid <= 1'b0;
            if (chan != LAST_CHAN) chan <= chan + 4'd1;
          end else begin
            pool_data <= pooled[next_idx];
            pool_idx  <= pool_idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_chan_sequencer.sv
// Scoreboard bench for conv_chan_sequencer: stimulus pushes expected beats
// into a queue, a negedge monitor pops and compares each accepted beat.
module tb_conv_chan_sequencer;

  localparam int OUT_H = 12;
  localparam int OUT_W = 11;
  localparam int CHAN  = 10;
  localparam int DW    = 24;
  localparam int NB    = 30;
  localparam int PW    = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 conv_trigger;
  logic [3:0]           conv_chan;
  logic                 conv_valid = 1'b0;
  logic [3:0]           conv_out_chan = '0;
  logic signed [DW-1:0] conv_buff [OUT_H][OUT_W];
  logic signed [DW-1:0] pool_data;
  logic                 pool_valid;
  logic                 pool_ready = 1'b1;
  logic [3:0]           pool_chan;
  logic [7:0]           pool_idx;
  logic                 busy, done, err;

  conv_chan_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .conv_trigger(conv_trigger), .conv_chan(conv_chan),
    .conv_valid(conv_valid), .conv_out_chan(conv_out_chan), .conv_buff(conv_buff),
    .pool_data(pool_data), .pool_valid(pool_valid), .pool_ready(pool_ready),
    .pool_chan(pool_chan), .pool_idx(pool_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     chan;
    int     idx;
    longint data;
  } beat_t;

  beat_t sb [$];

  int checks = 0;
  int failures = 0;

  // Conv model controls.
  int   conv_lat = 133;
  int   silent_chan = -1;
  int   bad_chan = -1;
  logic [3:0] bad_tag = '0;
  bit   stray_en = 1'b0;
  bit   rand_ready = 1'b0;
  int   trig0_cyc = -1;
  int   trig4_cyc = -1;
  logic [3:0] model_ch;

  // Monitor observations.
  int     done_cnt = 0;
  int     beat_cnt = 0;
  int     err_rise_cyc = -1;
  int     first_pv_cyc = -1;
  longint b00 = -1;
  longint b54 = -1;
  bit     err_prev = 1'b0;
  bit     hold_pend = 1'b0;
  logic [36:0] hold_vec = '0;
  beat_t  e;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint exp_beat(input int k);
    int r = k / PW;
    int c = k % PW;
    longint m = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (conv_buff[2*r+i][2*c+j] > m) m = conv_buff[2*r+i][2*c+j];
    return m;
  endfunction

  task automatic fill_ramp();
    for (int r = 0; r < OUT_H; r++)
      for (int c = 0; c < OUT_W; c++)
        conv_buff[r][c] = DW'(16 * r + c);
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < OUT_H; r++)
      for (int c = 0; c < OUT_W; c++)
        conv_buff[r][c] = DW'(v);
  endtask

  task automatic push_run(input int nchan);
    beat_t b;
    for (int ch = 0; ch < nchan; ch++)
      for (int k = 0; k < NB; k++) begin
        b.chan = ch;
        b.idx  = k;
        b.data = exp_beat(k);
        sb.push_back(b);
      end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run(input string tag, input int nchan, input bit exp_err, input bit restart_mid);
    done_cnt     = 0;
    beat_cnt     = 0;
    err_rise_cyc = -1;
    first_pv_cyc = -1;
    push_run(nchan);
    pulse_start();
    if (restart_mid) begin
      repeat (50) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < 6000 && done_cnt == 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_beats"}, beat_cnt, nchan * NB);
    check({tag, "_sb_left"}, sb.size(), 0);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_busy_after"}, busy, 0);
    sb.delete();
  endtask

  // Pool-ready driver: always ready, or a coin flip each cycle.
  initial forever begin
    @(posedge clk);
    #1 pool_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Conv engine model: answers each trigger conv_lat cycles later.
  initial forever begin
    @(negedge clk);
    if (rst_n && conv_trigger) begin
      model_ch = conv_chan;
      if (model_ch == 4'd0) trig0_cyc = cyc;
      if (int'(model_ch) == silent_chan) trig4_cyc = cyc;
      if (int'(model_ch) != silent_chan) begin
        repeat (conv_lat) @(posedge clk);
        #1 conv_valid = 1'b1;
        conv_out_chan = (int'(model_ch) == bad_chan) ? bad_tag : model_ch;
        @(posedge clk); #1 conv_valid = 1'b0;
        if (stray_en) begin
          repeat (3) @(posedge clk);
          #1 conv_valid = 1'b1;
          conv_out_chan = model_ch + 4'd1;
          @(posedge clk); #1 conv_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard compare on handshake, hold check while stalled.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      hold_pend = 1'b0;
      err_prev  = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (err && !err_prev && err_rise_cyc < 0) err_rise_cyc = cyc;
      err_prev = err;
      if (hold_pend)
        check("hold_stable", {pool_valid, pool_chan, pool_idx, pool_data}, hold_vec);
      if (pool_valid) begin
        if (pool_chan == 4'd0 && pool_idx == 8'd0 && first_pv_cyc < 0) first_pv_cyc = cyc;
        if (pool_ready) begin
          beat_cnt++;
          hold_pend = 1'b0;
          if (pool_chan == 4'd0 && pool_idx == 8'd0)  b00 = pool_data;
          if (pool_chan == 4'd0 && pool_idx == 8'd29) b54 = pool_data;
          check("beat_expected", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("beat_chan", pool_chan, e.chan);
            check("beat_idx", pool_idx, e.idx);
            check("beat_data", pool_data, e.data);
          end
        end else begin
          hold_pend = 1'b1;
          hold_vec  = {pool_valid, pool_chan, pool_idx, pool_data};
        end
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  initial begin
    fill_ramp();
    #1 check("reset_outputs",
             {conv_trigger, pool_valid, busy, done, err, conv_chan, pool_chan, pool_idx, pool_data}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Ramp map, always ready, stray conv_valid pulses and a mid-run start.
    stray_en = 1'b1;
    b00 = -1;
    b54 = -1;
    run("ramp", CHAN, 1'b0, 1'b1);
    stray_en = 1'b0;
    check("ramp_beat_0_0", b00, 17);
    check("ramp_beat_5_4", b54, 185);
    check("ramp_latency", first_pv_cyc - trig0_cyc, conv_lat + 2);

    // All-negative map pools to zero everywhere.
    fill_const(-5);
    run("neg", CHAN, 1'b0, 1'b0);

    // Random backpressure.
    fill_ramp();
    rand_ready = 1'b1;
    run("rand", CHAN, 1'b0, 1'b0);
    rand_ready = 1'b0;

    // Wrong channel tag on channel 2.
    bad_chan = 2;
    bad_tag  = 4'd3;
    run("badtag", CHAN, 1'b1, 1'b0);
    bad_chan = -1;

    // Channel 4 never answered: abort after the timeout.
    silent_chan = 4;
    run("timeout", 4, 1'b1, 1'b0);
    check("timeout_err_delay", err_rise_cyc - trig4_cyc, 1025);
    silent_chan = -1;

    // Reset in the middle of emitting beat 12 of channel 0.
    push_run(1);
    pulse_start();
    begin
      int n = 0;
      while (!(pool_valid && pool_chan == 4'd0 && pool_idx == 8'd12) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("rst_reach_beat12", n < 2000, 1);
    end
    #2 rst_n = 1'b0;
    #1 check("rst_mid_outputs",
             {conv_trigger, pool_valid, busy, done, err, conv_chan, pool_chan, pool_idx, pool_data}, 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    run("rerun", CHAN, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
